// File: rtl/clock_div_multi.sv
// clock_div_multi
//   Multi-channel programmable clock divider. Each channel runs a counter
//   against its own active period and high time and produces a registered
//   divided clock plus a one-cycle tick at the start of every period.
//   Configuration writes land in a per-channel shadow and are only applied
//   at a period boundary, or immediately while the channel is disabled. This
//   means a running output never sees a truncated or stretched period.
//
// Ports
//   clk_in      system clock
//   reset       asynchronous, active-high reset
//   en          per-channel run enable
//   sync        pulse: every enabled channel wraps on the next edge
//   cfg_wr      one-cycle config write strobe
//   cfg_ch      channel index of the write
//   cfg_period  new period in clk_in cycles (0 is rejected)
//   cfg_high    new high time in clk_in cycles
//   cfg_err     one-cycle pulse: the previous write was rejected
//   pend        channel holds a shadow config that is not yet applied
//   clk_out     divided clock per channel (registered)
//   tick        one-cycle pulse at the start of each period (registered)
module clock_div_multi #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_PER_C  = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_HIGH_C = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  // A write is accepted only for an existing channel with a non-zero period.
  // The extra bit keeps NUM_CH=16 representable in the comparison.
  logic cfg_ok;
  assign cfg_ok = ({1'b0, cfg_ch} < 5'(NUM_CH)) && (cfg_period != '0);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      // NOTE: registered state is always assigned with <= so every flop
      // samples the pre-edge values, independent of statement order.
      cfg_err <= cfg_wr && !cfg_ok;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per_act;
    logic [CNT_W-1:0] high_act;
    logic [CNT_W-1:0] sh_per;
    logic [CNT_W-1:0] sh_high;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;

    logic             wr_hit;
    logic             wrap;
    logic             apply;
    logic [CNT_W-1:0] per_new;
    logic [CNT_W-1:0] high_new;
    logic [CNT_W-1:0] cnt_new;

    assign wr_hit = cfg_wr && cfg_ok && (cfg_ch == 4'(i));

    always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // so no path leaves a value unassigned and no latch is inferred.
      per_new  = per_act;
      high_new = high_act;

      // sync only affects running channels; coinciding with a natural wrap
      // still produces a single wrap.
      wrap  = en[i] && ((cnt == per_act - ONE) || sync);
      // Config changes only at a boundary or while parked; a write in the
      // same cycle overrides the older shadow contents.
      apply = (wrap || !en[i]) && (pend_q || wr_hit);

      if (apply) begin
        per_new  = wr_hit ? cfg_period : sh_per;
        high_new = wr_hit ? cfg_high   : sh_high;
      end

      // A disabled channel is held one count before wrap, so the first
      // enabled edge starts a fresh period with a tick.
      if (!en[i]) begin
        cnt_new = per_new - ONE;
      end else if (wrap) begin
        cnt_new = '0;
      end else begin
        cnt_new = cnt + ONE;
      end
    end

    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        cnt      <= DEF_PER_C - ONE;
        per_act  <= DEF_PER_C;
        high_act <= DEF_HIGH_C;
        // NOTE: the shadow registers are a handful of flops, not a RAM, so
        // they are reset with everything else to keep pend/shadow coherent.
        sh_per   <= '0;
        sh_high  <= '0;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt      <= cnt_new;
        per_act  <= per_new;
        high_act <= high_new;
        if (wr_hit) begin
          sh_per  <= cfg_period;
          sh_high <= cfg_high;
        end
        if (apply) begin
          pend_q <= 1'b0;
        end else if (wr_hit) begin
          pend_q <= 1'b1;
        end
        // high_act >= per_act yields a constant 1; high_act == 0 a constant 0.
        clk_q  <= en[i] && (cnt_new < high_new);
        tick_q <= wrap;
      end
    end

    assign pend[i]    = pend_q;
    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// tb_clock_div_multi
//   Directed bench for clock_div_multi (NUM_CH=4, CNT_W=16, reset defaults
//   period 10 / high 5). Inputs change just after a falling edge and outputs
//   are sampled on the following falling edge, away from the active edge.
module tb_clock_div_multi;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [3:0]  en;
  logic        sync;
  logic        cfg_wr;
  logic [3:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic [15:0] cfg_high;
  logic        cfg_err;
  logic [3:0]  pend;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  int n_checks = 0;
  int n_pass   = 0;

  clock_div_multi #(
    .NUM_CH    (4),
    .CNT_W     (16),
    .DEF_PERIOD(10),
    .DEF_HIGH  (5)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .en        (en),
    .sync      (sync),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .cfg_high  (cfg_high),
    .cfg_err   (cfg_err),
    .pend      (pend),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic write(input logic [3:0] ch, input logic [15:0] per, input logic [15:0] hi);
    cfg_wr     = 1'b1;
    cfg_ch     = ch;
    cfg_period = per;
    cfg_high   = hi;
  endtask

  initial begin
    logic found;
    reset = 1'b1; en = '0; sync = 1'b0;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
    step();
    step();
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_tick",    32'(tick),    32'h0);
    check("rst_pend",    32'(pend),    32'h0);
    check("rst_cfg_err", 32'(cfg_err), 32'h0);

    // Default 10/5 on ch0; first enabled edge is a wrap.
    reset = 1'b0;
    en    = 4'b0001;
    for (int k = 0; k < 23; k++) begin
      step();
      check("def_clk",  32'(clk_out), 32'({3'b000, (k % 10) < 5}));
      check("def_tick", 32'(tick),    32'({3'b000, (k % 10) == 0}));
    end

    // Mid-period write (ch0 count 2 -> 3): current period finishes at 10/5.
    write(4'd0, 16'd4, 16'd1);
    step();
    cfg_wr = 1'b0;
    check("mid_pend_set", 32'(pend), 32'h1);
    check("mid_clk_c3",   32'(clk_out[0]), 32'h1);
    for (int k = 4; k < 10; k++) begin
      step();
      check("mid_old_clk",  32'(clk_out[0]), 32'(k < 5));
      check("mid_old_tick", 32'(tick[0]),    32'h0);
    end
    check("mid_pend_hold", 32'(pend[0]), 32'h1);
    for (int j = 0; j < 8; j++) begin
      step();
      if (j == 0) check("mid_pend_clr", 32'(pend[0]), 32'h0);
      check("new_clk",  32'(clk_out[0]), 32'((j % 4) == 0));
      check("new_tick", 32'(tick[0]),    32'((j % 4) == 0));
    end

    // ch1: period 4 high 0 applied while parked, then run -> constant 0.
    write(4'd1, 16'd4, 16'd0);
    step();
    cfg_wr = 1'b0;
    check("h0_pend_parked", 32'(pend[1]), 32'h0);
    check("h0_clk_parked",  32'(clk_out[1]), 32'h0);
    en = 4'b0011;
    for (int j = 0; j < 8; j++) begin
      step();
      check("h0_clk",  32'(clk_out[1]), 32'h0);
      check("h0_tick", 32'(tick[1]),    32'((j % 4) == 0));
    end
    // Write high 7 coinciding with ch1 wrap edge: takes effect on that edge.
    write(4'd1, 16'd4, 16'd7);
    for (int j = 0; j < 8; j++) begin
      step();
      if (j == 0) begin
        cfg_wr = 1'b0;
        check("h7_pend", 32'(pend[1]), 32'h0);
      end
      check("h7_clk",  32'(clk_out[1]), 32'h1);
      check("h7_tick", 32'(tick[1]),    32'((j % 4) == 0));
    end

    // Rejected writes: bad channel (5 and boundary 4) and zero period.
    write(4'd5, 16'd4, 16'd1);
    step();
    cfg_wr = 1'b0;
    check("err_ch5",      32'(cfg_err), 32'h1);
    check("err_ch5_pend", 32'(pend),    32'h0);
    step();
    check("err_ch5_drop", 32'(cfg_err), 32'h0);
    write(4'd4, 16'd4, 16'd1);
    step();
    cfg_wr = 1'b0;
    check("err_ch4", 32'(cfg_err), 32'h1);
    write(4'd0, 16'd0, 16'd1);
    step();
    cfg_wr = 1'b0;
    check("err_per0",      32'(cfg_err), 32'h1);
    check("err_per0_pend", 32'(pend),    32'h0);
    step();
    check("err_per0_drop", 32'(cfg_err), 32'h0);

    // Back-to-back writes to ch0 (7/3 then 6/3): last wins.
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (tick[0]) found = 1'b1;
    end
    check("b2b_tick_seen", 32'(found), 32'h1);
    write(4'd0, 16'd7, 16'd3);
    step();
    check("b2b_pend1", 32'(pend[0]), 32'h1);
    write(4'd0, 16'd6, 16'd3);
    step();
    cfg_wr = 1'b0;
    check("b2b_pend2", 32'(pend[0]), 32'h1);
    step();
    for (int j = 0; j < 12; j++) begin
      step();
      if (j == 0) check("b2b_pend_clr", 32'(pend[0]), 32'h0);
      check("b2b_clk",  32'(clk_out[0]), 32'((j % 6) < 3));
      check("b2b_tick", 32'(tick[0]),    32'((j % 6) == 0));
    end

    // ch1 period 9 high 4 while parked, restart it out of phase, then sync.
    en = 4'b0001;
    write(4'd1, 16'd9, 16'd4);
    step();
    cfg_wr = 1'b0;
    check("sy_park_pend", 32'(pend[1]),    32'h0);
    check("sy_park_clk",  32'(clk_out[1]), 32'h0);
    check("sy_park_tick", 32'(tick[1]),    32'h0);
    en = 4'b0011;
    step();
    check("sy_ch1_start", 32'(tick[1]), 32'h1);
    step();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sy_tick",    32'(tick),    32'h3);
    check("sy_clk_out", 32'(clk_out), 32'h3);
    for (int j = 1; j < 18; j++) begin
      step();
      check("sy_clk",  32'(clk_out), 32'({2'b00, (j % 9) < 4, (j % 6) < 3}));
      check("sy_tick", 32'(tick),    32'({2'b00, (j % 9) == 0, (j % 6) == 0}));
    end

    // Reset during ch0 high phase with a pending write.
    step();
    write(4'd0, 16'd3, 16'd1);
    step();
    cfg_wr = 1'b0;
    check("rm_pend_pre", 32'(pend[0]),    32'h1);
    check("rm_clk_pre",  32'(clk_out[0]), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rm_clk_now",  32'(clk_out), 32'h0);
    check("rm_pend_now", 32'(pend),    32'h0);
    check("rm_tick_now", 32'(tick),    32'h0);
    step();
    check("rm_clk_held", 32'(clk_out), 32'h0);
    en    = 4'b0001;
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check("rm_def_clk",  32'(clk_out), 32'({3'b000, (k % 10) < 5}));
      check("rm_def_tick", 32'(tick),    32'({3'b000, (k % 10) == 0}));
    end
    check("rm_pend_after", 32'(pend), 32'h0);

    // Period 1 on ch2: tick and clk_out constant 1 while enabled.
    write(4'd2, 16'd1, 16'd1);
    step();
    cfg_wr = 1'b0;
    en = 4'b0101;
    for (int j = 0; j < 4; j++) begin
      step();
      check("p1_tick", 32'(tick[2]),    32'h1);
      check("p1_clk",  32'(clk_out[2]), 32'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
